serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_if.sv | 46 ++++
 rtl/full_adder.sv | 21 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Purpose  : Shared state encoding and default operand width for serial_adder.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_if.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_if
// Purpose  : Operand/result handshake bundle; ovf exists only when
//            SERIAL_ADDER_OVF_EN is defined.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );

endinterface : serial_adder_if

`default_nettype wire

// File: rtl/full_adder.sv
//------------------------------------------------------------------------------
// Module   : full_adder
// Purpose  : Single-bit full-adder cell.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
    input  wire logic x,
    input  wire logic y,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_adder
// Purpose  : Bit-serial adder, one bit per clock through a single full-adder
//            cell. Define SERIAL_ADDER_OVF_EN to add the signed-overflow flag.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     rst,
    serial_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_carry_msb;
`endif

    full_adder u_fa (
        .x    (r_a_sh[0]),
        .y    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_carry_msb <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so bit 0 lands in the LSB after WIDTH shifts.
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
`ifdef SERIAL_ADDER_OVF_EN
                        r_carry_msb <= r_carry;
`endif
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
`ifdef SERIAL_ADDER_OVF_EN
    // Carry held in r_carry after the MSB cell is the final carry-out.
    assign bus.ovf       = r_carry_msb ^ r_carry;
`endif

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder at WIDTH=8.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   edge_cnt;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one operand set, checks latency and result, then drains with out_ready.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input logic [7:0] esum, input logic ecout,
                          input logic eovf);
        int k;
        bus.a = ia; bus.b = ib; bus.cin = ic; bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(W));
        check({tag, "_sum"}, 64'(bus.sum), 64'(esum));
        check({tag, "_cout"}, 64'(bus.cout), 64'(ecout));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(eovf));
`else
        if (eovf === 1'bx) $display("unused");
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_back_idle"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
    endtask

    logic [7:0] q_a    [3] = '{8'h12, 8'h80, 8'hFE};
    logic [7:0] q_b    [3] = '{8'h34, 8'h80, 8'h03};
    logic       q_c    [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] q_sum  [3] = '{8'h46, 8'h01, 8'h01};
    logic       q_cout [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        int acc_edge [3];
        int n_acc;
        int n_rcv;
        int guard;
        bit took;
        total = 0; bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, with in_valid and out_ready asserted alongside rst.
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_op("op0F01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op("opFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("op0000c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run_op("op7F01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Stall in DONE with in_valid toggling: result must hold, nothing accepted.
        bus.a = 8'hA5; bus.b = 8'h5A; bus.cin = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("stall_busy", 64'(bus.busy), 64'd1);
        repeat (W) @(negedge clk);
        bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_sum", 64'(bus.sum), 64'h00);
            check("stall_cout", 64'(bus.cout), 64'd1);
            bus.in_valid = ~bus.in_valid;
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        check("stall_held_sum", 64'(bus.sum), 64'h00);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("stall_release_idle", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);

        // Reset after three SHIFT cycles abandons the operation.
        bus.a = 8'h44; bus.b = 8'h44; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        run_op("op2211", 8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        n_acc = 0; n_rcv = 0; guard = 0;
        bus.a = q_a[0]; bus.b = q_b[0]; bus.cin = q_c[0];
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        while (n_rcv < 3 && guard < 100) begin
            took = 1'b0;
            if (bus.out_valid) begin
                check("b2b_sum", 64'(bus.sum), 64'(q_sum[n_rcv]));
                check("b2b_cout", 64'(bus.cout), 64'(q_cout[n_rcv]));
                n_rcv++;
            end
            if (bus.in_ready && bus.in_valid) begin
                acc_edge[n_acc] = edge_cnt + 1;
                n_acc++;
                took = 1'b1;
            end
            @(negedge clk);
            guard++;
            if (took) begin
                if (n_acc < 3) begin
                    bus.a = q_a[n_acc]; bus.b = q_b[n_acc]; bus.cin = q_c[n_acc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("b2b_results", 64'(n_rcv), 64'd3);
        if (n_acc == 3) begin
            check("b2b_gap1", 64'(acc_edge[1] - acc_edge[0]), 64'd10);
            check("b2b_gap2", 64'(acc_edge[2] - acc_edge[1]), 64'd10);
        end else begin
            check("b2b_accepts", 64'(n_acc), 64'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire
